// File: rtl/acc_seq_ctrl.sv
// Purpose: sequences one accelerator command: load A/B from RAM, start, wait, store the result.
// Latency: len+1 cycles per operand load with continuous grant; start 11 cycles after accept for len=4.
// Backpressure: a low ram_gnt_i holds request/address/data stable; commands are taken only in IDLE.
module acc_seq_ctrl #(
    parameter int ADDR_WIDTH = 15,
    parameter int NUM_WORDS  = 256,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_src_a_i,
    input  logic [ADDR_WIDTH-1:0] cmd_src_b_i,
    input  logic [ADDR_WIDTH-1:0] cmd_dst_i,
    input  logic [8:0]            cmd_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  ram_req_o,
    input  logic                  ram_gnt_i,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i,
    output logic                  acc_wr_a_o,
    output logic                  acc_wr_b_o,
    output logic [7:0]            acc_idx_o,
    output logic [31:0]           acc_wdata_o,
    output logic                  acc_start_o,
    input  logic                  acc_done_i,
    input  logic [31:0]           acc_out_i
);

    localparam int              WW        = $clog2(TIMEOUT + 1);
    localparam logic [8:0]      MAX_LEN   = 9'(NUM_WORDS);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_STORE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_a_q, src_a_d;
    logic [ADDR_WIDTH-1:0] src_b_q, src_b_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [8:0]            len_q, len_d;
    logic [8:0]            issue_q, issue_d;   // reads issued in LOAD, words stored (k) in STORE
    logic [8:0]            ret_q, ret_d;       // read data words returned in LOAD
    logic [WW-1:0]         wait_q, wait_d;
    logic                  rvld_q, rvld_d;     // a granted read returns data this cycle
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] offs;
    logic [8:0]            ret_inc;

    assign done_o = done_q;
    assign err_o  = err_q;

    // Word offset of the current issue/store index; the sum wraps modulo the RAM size
    // and the low two bits are forced to zero so the command's bits[1:0] never matter.
    assign offs    = ADDR_WIDTH'({issue_q, 2'b00});
    assign ret_inc = ret_q + 9'd1;

    // Next-state, counters and all outputs of the sequencer.
    always_comb begin
        state_d     = state_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        dst_d       = dst_q;
        len_d       = len_q;
        issue_d     = issue_q;
        ret_d       = ret_q;
        wait_d      = wait_q;
        rvld_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        base        = '0;
        cmd_ready_o = 1'b0;
        busy_o      = (state_q != S_IDLE);
        ram_req_o   = 1'b0;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_wdata_o = '0;
        acc_wr_a_o  = 1'b0;
        acc_wr_b_o  = 1'b0;
        acc_idx_o   = '0;
        acc_wdata_o = '0;
        acc_start_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    src_a_d = cmd_src_a_i;
                    src_b_d = cmd_src_b_i;
                    dst_d   = cmd_dst_i;
                    len_d   = cmd_len_i;
                    if (cmd_len_i == 9'd0 || cmd_len_i > MAX_LEN) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_LOAD_A;
                        issue_d = '0;
                        ret_d   = '0;
                    end
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                base = (state_q == S_LOAD_A) ? src_a_q : src_b_q;
                if (issue_q < len_q) begin
                    ram_req_o  = 1'b1;
                    ram_addr_o = (base + offs) & ~ADDR_WIDTH'(3);
                    if (ram_gnt_i) begin
                        issue_d = issue_q + 9'd1;
                        rvld_d  = 1'b1;
                    end
                end
                if (rvld_q) begin
                    acc_wr_a_o  = (state_q == S_LOAD_A);
                    acc_wr_b_o  = (state_q == S_LOAD_B);
                    acc_idx_o   = ret_q[7:0];
                    acc_wdata_o = ram_rdata_i;
                    ret_d       = ret_inc;
                    if (ret_inc == len_q) begin
                        state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_START;
                        issue_d = '0;
                        ret_d   = '0;
                    end
                end
            end
            S_START: begin
                acc_start_o = 1'b1;
                wait_d      = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (acc_done_i) begin
                    state_d = S_STORE;
                    issue_d = '0;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_STORE: begin
                ram_req_o   = 1'b1;
                ram_we_o    = 1'b1;
                acc_idx_o   = issue_q[7:0];
                ram_addr_o  = (dst_q + offs) & ~ADDR_WIDTH'(3);
                ram_wdata_o = acc_out_i;
                if (ram_gnt_i) begin
                    if (issue_q == len_q - 9'd1) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        issue_d = issue_q + 9'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte enables are all-on whenever a RAM access is presented, quiet otherwise.
    assign ram_be_o = ram_req_o ? 4'hF : 4'h0;

    // State and counter registers; reset drops any command in flight without a pulse.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            issue_q <= '0;
            ret_q   <= '0;
            wait_q  <= '0;
            rvld_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            issue_q <= issue_d;
            ret_q   <= ret_d;
            wait_q  <= wait_d;
            rvld_q  <= rvld_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed bench for acc_seq_ctrl with a word RAM model and an accelerator buffer model.
// Accelerator output is A[idx]+B[idx]; RAM word w initially holds pat(w).
// Grant is either continuous or alternating per cycle.
module tb_acc_seq_ctrl;

    localparam int TO = 32;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [14:0] cmd_src_a_i = '0;
    logic [14:0] cmd_src_b_i = '0;
    logic [14:0] cmd_dst_i = '0;
    logic [8:0]  cmd_len_i = '0;
    logic        busy_o, done_o, err_o;
    logic        ram_req_o;
    logic        ram_gnt_i;
    logic [14:0] ram_addr_o;
    logic        ram_we_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i = '0;
    logic        acc_wr_a_o, acc_wr_b_o;
    logic [7:0]  acc_idx_o;
    logic [31:0] acc_wdata_o;
    logic        acc_start_o;
    logic        acc_done_i = 1'b0;
    logic [31:0] acc_out_i;

    logic [31:0] mem  [8192];
    logic [31:0] bufa [256];
    logic [31:0] bufb [256];
    logic        init = 1'b1;
    logic        gnt_toggle = 1'b0;
    logic        phase = 1'b0;
    logic [14:0] rd_log[$];
    int          wr_cnt = 0;
    int          bad_both = 0, bad_req = 0, bad_hold = 0;
    logic        pend = 1'b0;
    logic [14:0] p_addr;
    logic        p_we;
    logic [31:0] p_wdata;

    int n_chk = 0;
    int n_fail = 0;
    int n;
    int w0;
    int rl;

    always #5 clk = ~clk;

    acc_seq_ctrl #(.ADDR_WIDTH(15), .NUM_WORDS(256), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_src_a_i(cmd_src_a_i), .cmd_src_b_i(cmd_src_b_i),
        .cmd_dst_i(cmd_dst_i), .cmd_len_i(cmd_len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .ram_req_o(ram_req_o), .ram_gnt_i(ram_gnt_i), .ram_addr_o(ram_addr_o),
        .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i),
        .acc_wr_a_o(acc_wr_a_o), .acc_wr_b_o(acc_wr_b_o), .acc_idx_o(acc_idx_o),
        .acc_wdata_o(acc_wdata_o), .acc_start_o(acc_start_o),
        .acc_done_i(acc_done_i), .acc_out_i(acc_out_i)
    );

    function automatic logic [31:0] pat(input int w);
        return (32'(w) * 32'h0001_0001) ^ 32'hA5C3_0F00;
    endfunction

    assign acc_out_i = bufa[acc_idx_o] + bufb[acc_idx_o];
    assign ram_gnt_i = gnt_toggle ? phase : 1'b1;

    always @(posedge clk) phase <= ~phase;

    // RAM model: one-cycle read latency, write on the granted cycle.
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 8192; i++) mem[i] <= pat(i);
        end else if (ram_req_o && ram_gnt_i) begin
            if (ram_we_o) begin
                mem[ram_addr_o[14:2]] <= ram_wdata_o;
                wr_cnt <= wr_cnt + 1;
            end else begin
                ram_rdata_i <= mem[ram_addr_o[14:2]];
                rd_log.push_back(ram_addr_o);
            end
        end
    end

    // Accelerator input buffers.
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 256; i++) begin
                bufa[i] <= 32'hDEAD_BEEF;
                bufb[i] <= 32'hDEAD_BEEF;
            end
        end else begin
            if (acc_wr_a_o) bufa[acc_idx_o] <= acc_wdata_o;
            if (acc_wr_b_o) bufb[acc_idx_o] <= acc_wdata_o;
        end
    end

    // Protocol watchers, sampled mid-cycle.
    always @(negedge clk) begin
        if (done_o && err_o) bad_both = bad_both + 1;
        if (ram_req_o && !busy_o) bad_req = bad_req + 1;
        if (pend && (!ram_req_o || ram_addr_o != p_addr || ram_we_o != p_we || ram_wdata_o != p_wdata))
            bad_hold = bad_hold + 1;
        pend    = ram_req_o && !ram_gnt_i && !rst_i;
        p_addr  = ram_addr_o;
        p_we    = ram_we_o;
        p_wdata = ram_wdata_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_cmd_ready"}, 32'(cmd_ready_o), 1);
        chk({p, "_busy"},      32'(busy_o), 0);
        chk({p, "_done"},      32'(done_o), 0);
        chk({p, "_err"},       32'(err_o), 0);
        chk({p, "_req"},       32'(ram_req_o), 0);
        chk({p, "_addr"},      32'(ram_addr_o), 0);
        chk({p, "_we"},        32'(ram_we_o), 0);
        chk({p, "_be"},        32'(ram_be_o), 0);
        chk({p, "_wdata"},     ram_wdata_o, 0);
        chk({p, "_wr_a"},      32'(acc_wr_a_o), 0);
        chk({p, "_wr_b"},      32'(acc_wr_b_o), 0);
        chk({p, "_idx"},       32'(acc_idx_o), 0);
        chk({p, "_acc_wdata"}, acc_wdata_o, 0);
        chk({p, "_start"},     32'(acc_start_o), 0);
    endtask

    task automatic send(input logic [14:0] a, input logic [14:0] b, input logic [14:0] d,
                        input logic [8:0] len);
        cmd_src_a_i = a;
        cmd_src_b_i = b;
        cmd_dst_i   = d;
        cmd_len_i   = len;
        cmd_valid_i = 1'b1;
        chk("cmd_ready_at_accept", 32'(cmd_ready_o), 1);
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_start(output int cnt);
        cnt = 0;
        while (!acc_start_o && cnt < 2000) begin
            tick();
            cnt++;
        end
        chk("start_seen", 32'(acc_start_o), 1);
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!done_o && cnt < 2000) begin
            tick();
            cnt++;
        end
        chk("done_seen", 32'(done_o), 1);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        init = 1'b0;
        chk_reset("rst");
        rst_i = 1'b0;
        tick();

        // Test 1: len=4 load with continuous grant; start at cycle 11 after accept
        rd_log.delete();
        send(15'h100, 15'h200, 15'h300, 9'd4);
        wait_start(n);
        chk("t1_start_cycle", 32'(n + 1), 11);
        for (int k = 0; k < 4; k++) begin
            chk("t1_bufa", bufa[k], pat(32'h40 + k));
            chk("t1_bufb", bufb[k], pat(32'h80 + k));
        end
        chk("t1_bufa_idx4_untouched", bufa[4], 32'hDEAD_BEEF);
        chk("t1_reads", 32'(rd_log.size()), 8);
        for (int k = 0; k < 4; k++) begin
            chk("t1_rd_addr_a", 32'(rd_log[k]), 32'h100 + 4 * k);
            chk("t1_rd_addr_b", 32'(rd_log[4 + k]), 32'h200 + 4 * k);
        end

        // Test 2: acc_done 20 cycles after start, store to 0x300
        w0 = wr_cnt;
        repeat (20) tick();
        chk("t2_waiting_no_req", 32'(ram_req_o), 0);
        acc_done_i = 1'b1;
        tick();
        acc_done_i = 1'b0;
        chk("t2_store_req", 32'(ram_req_o), 1);
        chk("t2_store_we", 32'(ram_we_o), 1);
        chk("t2_store_be", 32'(ram_be_o), 32'hF);
        chk("t2_store_addr0", 32'(ram_addr_o), 32'h300);
        chk("t2_store_wdata0", ram_wdata_o, pat(32'h40) + pat(32'h80));
        wait_done(n);
        chk("t2_done_after_4th_write", 32'(n), 4);
        chk("t2_write_count", 32'(wr_cnt - w0), 4);
        for (int k = 0; k < 4; k++)
            chk("t2_mem", mem[32'hC0 + k], pat(32'h40 + k) + pat(32'h80 + k));
        tick();
        chk("t2_done_one_cycle", 32'(done_o), 0);
        chk("t2_idle", 32'(busy_o), 0);

        // Test 3: alternating grant, len=8; acc_done held high from accept
        gnt_toggle = 1'b1;
        rd_log.delete();
        send(15'h400, 15'h500, 15'h600, 9'd8);
        acc_done_i = 1'b1;
        wait_start(n);
        for (int k = 0; k < 8; k++) begin
            chk("t3_bufa", bufa[k], pat(32'h100 + k));
            chk("t3_bufb", bufb[k], pat(32'h140 + k));
        end
        chk("t3_reads", 32'(rd_log.size()), 16);
        for (int k = 0; k < 16; k++)
            chk("t3_rd_addr", 32'(rd_log[k]),
                (k < 8) ? 32'h400 + 4 * k : 32'h500 + 4 * (k - 8));
        tick();
        chk("t3_wait_busy", 32'(busy_o), 1);
        chk("t3_wait_no_req", 32'(ram_req_o), 0);
        tick();
        chk("t3_store_immediate", 32'(ram_req_o & ram_we_o), 1);
        acc_done_i = 1'b0;
        wait_done(n);
        for (int k = 0; k < 8; k++)
            chk("t3_mem", mem[32'h180 + k], pat(32'h100 + k) + pat(32'h140 + k));
        gnt_toggle = 1'b0;
        tick();

        // Test 4: illegal lengths 0 and 257, then the full 256
        rl = rd_log.size();
        send(15'h100, 15'h200, 15'h300, 9'd0);
        chk("t4_len0_err", 32'(err_o), 1);
        chk("t4_len0_idle", 32'(busy_o), 0);
        chk("t4_len0_ready", 32'(cmd_ready_o), 1);
        tick();
        chk("t4_len0_err_pulse", 32'(err_o), 0);
        send(15'h100, 15'h200, 15'h300, 9'd257);
        chk("t4_len257_err", 32'(err_o), 1);
        chk("t4_len257_done", 32'(done_o), 0);
        tick();
        chk("t4_len257_err_pulse", 32'(err_o), 0);
        chk("t4_no_reads", 32'(rd_log.size() - rl), 0);
        send(15'h1000, 15'h2000, 15'h3000, 9'd256);
        acc_done_i = 1'b1;
        wait_start(n);
        chk("t4_bufa0", bufa[0], pat(32'h400));
        chk("t4_bufa255", bufa[255], pat(32'h400 + 255));
        chk("t4_bufb255", bufb[255], pat(32'h800 + 255));
        wait_done(n);
        acc_done_i = 1'b0;
        chk("t4_mem0", mem[32'hC00], pat(32'h400) + pat(32'h800));
        chk("t4_mem255", mem[32'hC00 + 255], pat(32'h400 + 255) + pat(32'h800 + 255));
        tick();

        // Test 5: no acc_done -> timeout error, no store
        send(15'h10, 15'h20, 15'h5000, 9'd1);
        wait_start(n);
        tick();
        w0 = wr_cnt;
        n = 0;
        while (!err_o && n < 200) begin
            tick();
            n++;
        end
        chk("t5_err_cycle_into_wait", 32'(n), TO);
        chk("t5_idle", 32'(busy_o), 0);
        chk("t5_no_done", 32'(done_o), 0);
        chk("t5_no_writes", 32'(wr_cnt - w0), 0);
        tick();
        chk("t5_err_pulse", 32'(err_o), 0);

        // Test 6: reset during LOAD_B, then a command wrapping the RAM top
        send(15'h40, 15'h80, 15'h700, 9'd8);
        n = 0;
        while (!acc_wr_b_o && n < 100) begin
            tick();
            n++;
        end
        chk("t6_in_load_b", 32'(acc_wr_b_o), 1);
        rst_i = 1'b1;
        tick();
        chk_reset("t6_rst");
        rst_i = 1'b0;
        rd_log.delete();
        send(15'h7FFC, 15'h7FF8, 15'h7FFC, 9'd2);
        acc_done_i = 1'b1;
        wait_start(n);
        chk("t6_reads", 32'(rd_log.size()), 4);
        chk("t6_rd0", 32'(rd_log[0]), 32'h7FFC);
        chk("t6_rd1_wrap", 32'(rd_log[1]), 32'h0000);
        chk("t6_rd2", 32'(rd_log[2]), 32'h7FF8);
        chk("t6_rd3", 32'(rd_log[3]), 32'h7FFC);
        chk("t6_bufa1", bufa[1], pat(0));
        chk("t6_bufb0", bufb[0], pat(32'h1FFE));
        wait_done(n);
        acc_done_i = 1'b0;
        chk("t6_mem_top", mem[8191], pat(32'h1FFF) + pat(32'h1FFE));
        chk("t6_mem_wrap", mem[0], pat(0) + pat(32'h1FFF));
        tick();

        // Whole-run protocol properties
        chk("never_done_and_err", 32'(bad_both), 0);
        chk("no_req_in_idle", 32'(bad_req), 0);
        chk("req_held_until_gnt", 32'(bad_hold), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
